// File: rtl/dot_mmio_pkg.sv
// Dot MMIO address map and queued-entry layout shared by the dot write queue.
package dot_mmio_pkg;

  localparam int unsigned RNG_ADDR   = 32'd99;
  localparam int unsigned X_BASE     = 32'd100;
  localparam int unsigned Y_BASE     = 32'd550;
  localparam int unsigned TOP        = 32'd999;
  localparam int unsigned DOT_ID_W   = 32'd10;
  localparam int unsigned DOT_DATA_W = 32'd32;

  typedef struct packed {
    logic                  y;
    logic [DOT_ID_W-1:0]   id;
    logic [DOT_DATA_W-1:0] loc;
  } dot_entry_t;

endpackage

// File: rtl/dot_fifo_mem.sv
// Dot queue storage: DEPTH x WIDTH register array, one write port, one async read port.
module dot_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 43,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             wr_en_i,
  input  logic [PTR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [PTR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage write; contents are only meaningful between head and tail, so no reset.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/dot_write_queue.sv
// MMIO dot-write decoder and FIFO feeding the VGA dot-update port.
// Optional macro DOT_WRITE_QUEUE_COALESCE_EN merges repeated writes to the newest entry.
module dot_write_queue #(
  parameter int DEPTH  = 16,
  parameter int X_BASE = dot_mmio_pkg::X_BASE,
  parameter int Y_BASE = dot_mmio_pkg::Y_BASE,
  parameter int TOP    = dot_mmio_pkg::TOP,
  parameter int ID_W   = dot_mmio_pkg::DOT_ID_W,
  parameter int DATA_W = dot_mmio_pkg::DOT_DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mwe,
  input  logic [31:0]       address_dmem,
  input  logic [DATA_W-1:0] data,
  input  logic              drain_en,
  output logic              dotWren,
  output logic              is_Yloc,
  output logic [ID_W-1:0]   dotID,
  output logic [DATA_W-1:0] dotLoc,
  output logic              full,
  output logic              overflow,
  output logic [CNT_W-1:0]  count
);

  import dot_mmio_pkg::*;

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, wr_addr_s;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d, wren_q, wren_d, y_q, y_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] loc_q, loc_d;
  logic              hit_s, pop_s, push_s, coalesce_s, full_s, wr_en_s;
  dot_entry_t        new_s, rd_s;
`ifdef DOT_WRITE_QUEUE_COALESCE_EN
  logic              last_y_q, last_y_d;
  logic [ID_W-1:0]   last_id_q, last_id_d;
`endif

  // Address decode into a candidate queue entry.
  always_comb begin
    new_s = '0;
    hit_s = mwe && (address_dmem >= 32'(X_BASE)) && (address_dmem <= 32'(TOP));
    new_s.y = (address_dmem >= 32'(Y_BASE));
    if (new_s.y) begin
      new_s.id = ID_W'(address_dmem - 32'(Y_BASE));
    end else begin
      new_s.id = ID_W'(address_dmem - 32'(X_BASE));
    end
    new_s.loc = data;
  end

  // Push/pop/coalesce control and next-state.
  always_comb begin
    full_s = (count_q == CNT_W'(DEPTH));
    pop_s  = drain_en && (count_q != '0);
`ifdef DOT_WRITE_QUEUE_COALESCE_EN
    // A pop of the only entry would consume it this edge, so fall back to a push.
    coalesce_s = hit_s && (count_q != '0) && (last_y_q == new_s.y) &&
                 (last_id_q == new_s.id) && !(pop_s && (count_q == CNT_W'(1)));
`else
    coalesce_s = 1'b0;
`endif
    push_s    = hit_s && !coalesce_s && (!full_s || pop_s);
    wr_en_s   = push_s || coalesce_s;
    wr_addr_s = coalesce_s ? (tail_q - PTR_W'(1)) : tail_q;
    head_d    = pop_s ? (head_q + PTR_W'(1)) : head_q;
    tail_d    = push_s ? (tail_q + PTR_W'(1)) : tail_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q || (hit_s && !coalesce_s && full_s && !pop_s);
    wren_d     = pop_s;
    if (pop_s) begin
      y_d   = rd_s.y;
      id_d  = rd_s.id;
      loc_d = rd_s.loc;
    end else begin
      y_d   = y_q;
      id_d  = id_q;
      loc_d = loc_q;
    end
`ifdef DOT_WRITE_QUEUE_COALESCE_EN
    if (push_s) begin
      last_y_d  = new_s.y;
      last_id_d = new_s.id;
    end else begin
      last_y_d  = last_y_q;
      last_id_d = last_id_q;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      wren_q     <= 1'b0;
      y_q        <= 1'b0;
      id_q       <= '0;
      loc_q      <= '0;
`ifdef DOT_WRITE_QUEUE_COALESCE_EN
      last_y_q   <= 1'b0;
      last_id_q  <= '0;
`endif
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      wren_q     <= wren_d;
      y_q        <= y_d;
      id_q       <= id_d;
      loc_q      <= loc_d;
`ifdef DOT_WRITE_QUEUE_COALESCE_EN
      last_y_q   <= last_y_d;
      last_id_q  <= last_id_d;
`endif
    end
  end

  dot_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(dot_entry_t))
  ) u_mem (
    .clock     (clock),
    .wr_en_i   (wr_en_s),
    .wr_addr_i (wr_addr_s),
    .wr_data_i (new_s),
    .rd_addr_i (head_q),
    .rd_data_o (rd_s)
  );

  assign dotWren  = wren_q;
  assign is_Yloc  = y_q;
  assign dotID    = id_q;
  assign dotLoc   = loc_q;
  assign full     = full_s;
  assign overflow = overflow_q;
  assign count    = count_q;

endmodule

// File: tb/tb_dot_write_queue.sv
// Directed plus randomized bench for dot_write_queue against a queue-based reference model.
module tb_dot_write_queue;

  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        mwe;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        drain_en;
  logic        dotWren, is_Yloc, full, overflow;
  logic [9:0]  dotID;
  logic [31:0] dotLoc;
  logic [4:0]  count;

  always #5 clock = ~clock;

  dot_write_queue dut (
    .clock(clock), .reset(reset), .mwe(mwe), .address_dmem(address_dmem),
    .data(data), .drain_en(drain_en), .dotWren(dotWren), .is_Yloc(is_Yloc),
    .dotID(dotID), .dotLoc(dotLoc), .full(full), .overflow(overflow), .count(count)
  );

  typedef struct {
    bit          y;
    int unsigned id;
    int unsigned loc;
  } ent_t;

  ent_t        q[$];
  int          total = 0;
  int          bad = 0;
  bit          e_wren, e_y, e_ovf;
  int unsigned e_id, e_loc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".dotWren"},  32'(dotWren),  32'(e_wren));
    check({tag, ".is_Yloc"},  32'(is_Yloc),  32'(e_y));
    check({tag, ".dotID"},    32'(dotID),    e_id);
    check({tag, ".dotLoc"},   dotLoc,        e_loc);
    check({tag, ".count"},    32'(count),    32'(q.size()));
    check({tag, ".full"},     32'(full),     32'(q.size() == DEPTH));
    check({tag, ".overflow"}, 32'(overflow), 32'(e_ovf));
  endtask

  // Reference: one clock edge worth of queue behaviour.
  task automatic model_edge(input bit m, input int unsigned a, input int unsigned d, input bit dr);
    bit   pop, hit, co;
    ent_t n;
    pop   = dr && (q.size() != 0);
    hit   = m && (a >= 100) && (a <= 999);
    n.y   = (a >= 550);
    n.id  = (n.y ? a - 550 : a - 100) & 32'h3ff;
    n.loc = d;
    co    = 1'b0;
`ifdef DOT_WRITE_QUEUE_COALESCE_EN
    if (hit && q.size() != 0 && q[q.size()-1].y == n.y && q[q.size()-1].id == n.id &&
        !(pop && q.size() == 1))
      co = 1'b1;
`endif
    e_wren = pop;
    if (pop) begin
      e_y   = q[0].y;
      e_id  = q[0].id;
      e_loc = q[0].loc;
    end
    if (co) q[q.size()-1].loc = d;
    else if (hit) begin
      if (q.size() < DEPTH || pop) q.push_back(n);
      else e_ovf = 1'b1;
    end
    if (pop) void'(q.pop_front());
  endtask

  task automatic step(input string tag, input bit m, input int unsigned a, input int unsigned d, input bit dr);
    mwe = m; address_dmem = a; data = d; drain_en = dr;
    @(posedge clock);
    model_edge(m, a, d, dr);
    #1;
    check_all(tag);
  endtask

  task automatic model_clear();
    q.delete();
    e_wren = 1'b0; e_y = 1'b0; e_id = 0; e_loc = 0; e_ovf = 1'b0;
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic async_reset(input string tag);
    #1 reset = 1'b0;
    #1;
    model_clear();
    check_all(tag);
    #1 reset = 1'b1;
  endtask

  initial begin
    int unsigned a, r;
    reset = 1'b0; mwe = 1'b0; address_dmem = 32'd0; data = 32'd0; drain_en = 1'b0;
    model_clear();
    #12;
    check_all("reset");
    #1 reset = 1'b1;

    step("dec100", 1'b1, 100, 5, 1'b1);
    step("dec549", 1'b1, 549, 7, 1'b1);
    step("dec550", 1'b1, 550, 9, 1'b1);
    repeat (3) step("dec_drain", 1'b0, 0, 0, 1'b1);

    step("filt99",   1'b1, 99,   11, 1'b1);
    step("filt1000", 1'b1, 1000, 12, 1'b1);
    step("filt50",   1'b1, 50,   13, 1'b1);
    step("filtrd",   1'b0, 300,  14, 1'b1);
    step("filtidle", 1'b0, 0,    0,  1'b1);

    for (int i = 0; i < 17; i++) step("fill", 1'b1, 100 + i, 32'h100 + i, 1'b0);
    repeat (18) step("filldrain", 1'b0, 0, 0, 1'b1);

    async_reset("rst1");
    for (int i = 0; i < 16; i++) step("full_fill", 1'b1, 560 + i, 32'h200 + i, 1'b0);
    step("full_pushpop", 1'b1, 300, 32'habc, 1'b1);
    repeat (17) step("full_drain", 1'b0, 0, 0, 1'b1);

    for (int i = 0; i < 5; i++) step("mid_fill", 1'b1, 400 + i, 32'h300 + i, 1'b0);
    repeat (2) step("mid_drain", 1'b0, 0, 0, 1'b1);
    async_reset("rst_mid");
    repeat (3) step("post_rst", 1'b0, 0, 0, 1'b1);

    step("co1", 1'b1, 200, 1, 1'b0);
    step("co2", 1'b1, 200, 2, 1'b0);
    step("co3", 1'b1, 200, 3, 1'b0);
    repeat (4) step("co_drain", 1'b0, 0, 0, 1'b1);

    async_reset("rst_rand");
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0:       a = $urandom_range(0, 99);
        1:       a = $urandom_range(1000, 1100);
        2:       a = ($urandom_range(0, 1) == 0) ? 100 : 999;
        3:       a = ($urandom_range(0, 1) == 0) ? 549 : 550;
        4, 5:    a = 200 + $urandom_range(0, 1);
        default: a = $urandom_range(100, 999);
      endcase
      step("rand", ($urandom_range(0, 3) != 0), a, $urandom, ($urandom_range(0, 2) == 0));
    end
    repeat (20) step("rand_drain", 1'b0, 0, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
